// File: rtl/dbus_mem_responder_pkg.sv
// Shared types and constants for the LSU data-bus responder.
package dbus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int BYTE_W = 8;

  typedef struct packed {
    logic [31:0]        addr;
    logic               wr;
    logic [MASK_W-1:0]  mask;
    logic [DATA_W-1:0]  wdata;
  } req_t;
endpackage

// File: rtl/dbus_mem_responder_if.sv
// LSU data bus: master is the LSU, slave is the memory responder.
interface dbus_if;
  logic                       cs;
  logic                       wr;
  logic [dbus_pkg::MASK_W-1:0] mask;
  logic [31:0]                Mem_Addr;
  logic [dbus_pkg::DATA_W-1:0] Mem_Din;
  logic [dbus_pkg::DATA_W-1:0] Mem_Dout;
  logic                       ready;
  logic                       err;
  logic                       busy;

  modport master (output cs, wr, mask, Mem_Addr, Mem_Din,
                  input  Mem_Dout, ready, err, busy);
  modport slave  (input  cs, wr, mask, Mem_Addr, Mem_Din,
                  output Mem_Dout, ready, err, busy);
endinterface

// File: rtl/dmem_byte_array.sv
// Word-organised storage with per-byte write enables; sync write, sync read, no reset.
module dmem_byte_array
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic [MASK_W-1:0]  we,
  input  logic               re,
  input  logic [AW-1:0]      addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);
  logic [MASK_W-1:0][BYTE_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < MASK_W; b++) begin
      if (we[b]) mem[addr][b] <= wdata[b*BYTE_W +: BYTE_W];
    end
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dbus_mem_responder.sv
// Data-bus target with programmable wait states, byte-lane stores and range error.
module dbus_mem_responder
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  dbus_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state;
  logic [3:0]          cnt;
  req_t                req;
  logic                ready_q, err_q, busy_q;
  logic                dout_vld;
  logic [DATA_W-1:0]   rdata;

  req_t                acc;
  logic                acc_go;
  logic [31:0]         off;
  logic                in_range;
  logic [MASK_W-1:0]   we;
  logic                re;

  // With no wait states the access happens on the capture edge, straight from the bus.
  always_comb begin
    acc    = req;
    acc_go = 1'b0;
    unique case (state)
      IDLE: begin
        acc    = '{addr: bus.Mem_Addr, wr: bus.wr, mask: bus.mask, wdata: bus.Mem_Din};
        acc_go = bus.cs && (WAIT_CYCLES == 0);
      end
      WAIT:    acc_go = (cnt == 4'd0);
      default: ;
    endcase
  end

  assign off      = acc.addr - BASE_ADDR;
  assign in_range = off < SPAN;
  assign we       = (acc_go && in_range && acc.wr) ? acc.mask : '0;
  assign re       = acc_go && in_range && !acc.wr;

  dmem_byte_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .addr  (off[AW+1:2]),
    .wdata (acc.wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      req      <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: if (bus.cs) begin
          req    <= acc;
          busy_q <= 1'b1;
          if (WAIT_CYCLES == 0) state <= RESP;
          else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
              else             state <= RESP;
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (acc_go) begin
        ready_q <= 1'b1;
        err_q   <= !in_range;
        // Stores leave the last load data visible; loads and errors replace it.
        if (!acc.wr || !in_range) dout_vld <= in_range;
      end
    end
  end

  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.Mem_Dout = dout_vld ? rdata : '0;
endmodule

// File: tb/tb_dbus_mem_responder.sv
// Bench: transaction-level model of the responder checked every cycle, plus literal pins.
module tb_dbus_mem_responder;
  localparam int          W     = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] BASE0 = 32'h0001_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dbus_if bus();
  dbus_if bus0();

  dbus_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  dbus_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: "since" counts edges since capture; access on edge W, response ends on edge W+1.
  int          since = -1;
  logic [31:0] m_addr, m_din;
  logic        m_wr;
  logic [3:0]  m_mask;
  logic [31:0] mem_m [int unsigned];
  logic        e_ready = 0, e_err = 0, e_busy = 0;
  logic [31:0] e_dout = 0;

  task automatic model_access();
    logic [31:0] o, t;
    int unsigned idx;
    o = m_addr - BASE;
    e_ready = 1;
    if (o >= DEPTH * 4) begin
      e_err  = 1;
      e_dout = 0;
    end else begin
      idx = o / 4;
      if (m_wr) begin
        t = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (m_mask[b]) t[8*b +: 8] = m_din[8*b +: 8];
        mem_m[idx] = t;
      end else begin
        e_dout = mem_m.exists(idx) ? mem_m[idx] : 32'hxxxx_xxxx;
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      since = -1; e_ready = 0; e_err = 0; e_busy = 0; e_dout = 0;
    end else begin
      e_ready = 0; e_err = 0;
      if (since == W) begin
        since = -1; e_busy = 0;
      end else if (since >= 0) begin
        since++;
      end else if (bus.cs) begin
        m_addr = bus.Mem_Addr; m_wr = bus.wr; m_mask = bus.mask; m_din = bus.Mem_Din;
        since = 0; e_busy = 1;
      end
      if (since == W) model_access();
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("ready", 32'(bus.ready), 32'(e_ready));
      chk("err",   32'(bus.err),   32'(e_err));
      chk("busy",  32'(bus.busy),  32'(e_busy));
      chk("dout",  bus.Mem_Dout,   e_dout);
    end
  end

  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] d, output logic [31:0] q, output logic e,
                     output int lat);
    @(negedge clk);
    bus.cs = 1; bus.wr = w; bus.Mem_Addr = a; bus.mask = m; bus.Mem_Din = d;
    @(negedge clk);
    bus.cs = 0;
    lat = 1;
    while (!bus.ready && lat < 40) begin @(negedge clk); lat++; end
    q = bus.Mem_Dout; e = bus.err;
  endtask

  task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] q, output logic e, output int lat);
    @(negedge clk);
    bus0.cs = 1; bus0.wr = w; bus0.Mem_Addr = a; bus0.mask = 4'hF; bus0.Mem_Din = d;
    @(negedge clk);
    bus0.cs = 0;
    lat = 1;
    while (!bus0.ready && lat < 40) begin @(negedge clk); lat++; end
    q = bus0.Mem_Dout; e = bus0.err;
  endtask

  initial begin
    logic [31:0] q;
    logic        e;
    int          lat, n;
    bus.cs = 0; bus.wr = 0; bus.mask = 0; bus.Mem_Addr = 0; bus.Mem_Din = 0;
    bus0.cs = 0; bus0.wr = 0; bus0.mask = 0; bus0.Mem_Addr = 0; bus0.Mem_Din = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_dout",  bus.Mem_Dout, 0);
    reset = 0;
    repeat (4) @(negedge clk);
    chk("idle_ready", 32'(bus.ready), 0);
    chk("idle_busy",  32'(bus.busy), 0);

    for (int i = 0; i < 16; i++) txn(1, 32'(i * 4), 4'hF, 32'hC0DE_0000 | 32'(i), q, e, lat);

    txn(1, 32'h10, 4'hF, 32'hDEAD_BEEF, q, e, lat);
    chk("st_lat", 32'(lat), 3);
    chk("st_err", 32'(e), 0);
    txn(0, 32'h10, 4'h0, 32'h0, q, e, lat);
    chk("ld_lat", 32'(lat), 3);
    chk("ld_data", q, 32'hDEAD_BEEF);

    txn(1, 32'h10, 4'b0010, 32'h0000_AA00, q, e, lat);
    txn(0, 32'h12, 4'h0, 32'h0, q, e, lat);
    chk("lane_data", q, 32'hDEAD_AAEF);
    txn(1, 32'h10, 4'h0, 32'hFFFF_FFFF, q, e, lat);
    chk("mask0_lat", 32'(lat), 3);
    txn(0, 32'h10, 4'hF, 32'h0, q, e, lat);
    chk("mask0_data", q, 32'hDEAD_AAEF);

    txn(0, BASE + DEPTH * 4, 4'h0, 32'h0, q, e, lat);
    chk("oor_ld_err", 32'(e), 1);
    chk("oor_ld_dout", q, 0);
    txn(1, BASE + DEPTH * 4, 4'hF, 32'h9999_9999, q, e, lat);
    chk("oor_st_err", 32'(e), 1);
    txn(0, 32'h0, 4'h0, 32'h0, q, e, lat);
    chk("oor_noalias", q, 32'hC0DE_0000);
    txn(1, BASE + DEPTH * 4 - 4, 4'hF, 32'h1357_2468, q, e, lat);
    chk("last_st_err", 32'(e), 0);
    txn(0, BASE + DEPTH * 4 - 4, 4'h0, 32'h0, q, e, lat);
    chk("last_ld", q, 32'h1357_2468);

    // Request fields change and cs drops during WAIT.
    @(negedge clk);
    bus.cs = 1; bus.wr = 1; bus.Mem_Addr = 32'h30; bus.mask = 4'hF; bus.Mem_Din = 32'hAAAA_5555;
    @(negedge clk);
    bus.cs = 0; bus.wr = 0; bus.Mem_Addr = 32'h34; bus.mask = 4'h1; bus.Mem_Din = 32'h0BAD_F00D;
    lat = 1;
    while (!bus.ready && lat < 40) begin @(negedge clk); lat++; end
    chk("stab_lat", 32'(lat), 3);
    txn(0, 32'h30, 4'h0, 32'h0, q, e, lat);
    chk("stab_30", q, 32'hAAAA_5555);
    txn(0, 32'h34, 4'h0, 32'h0, q, e, lat);
    chk("stab_34", q, 32'hC0DE_000D);

    // cs held through RESP: second capture in the following IDLE cycle.
    @(negedge clk);
    bus.cs = 1; bus.wr = 0; bus.Mem_Addr = 32'h10; bus.mask = 4'h0;
    n = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.ready) n++; end
    bus.cs = 0;
    chk("held_cs_pulses", 32'(n), 2);
    repeat (2) @(negedge clk);

    // Reset during WAIT drops the pending store.
    @(negedge clk);
    bus.cs = 1; bus.wr = 1; bus.Mem_Addr = 32'h20; bus.mask = 4'hF; bus.Mem_Din = 32'h1234_5678;
    @(negedge clk);
    bus.cs = 0;
    chk("pre_rst_busy", 32'(bus.busy), 1);
    #2 reset = 1;
    #1;
    chk("async_ready", 32'(bus.ready), 0);
    chk("async_err",   32'(bus.err), 0);
    chk("async_busy",  32'(bus.busy), 0);
    chk("async_dout",  bus.Mem_Dout, 0);
    @(negedge clk);
    reset = 0;
    n = 0;
    repeat (6) begin @(negedge clk); if (bus.ready) n++; end
    chk("rst_no_ready", 32'(n), 0);
    txn(0, 32'h20, 4'h0, 32'h0, q, e, lat);
    chk("rst_dropped", q, 32'hC0DE_0008);

    // Free-running random traffic; the model follows every capture.
    for (int c = 0; c < 1500; c++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 9));
      bus.cs   = ($urandom_range(0, 2) == 0);
      bus.wr   = 1'($urandom);
      bus.mask = 4'($urandom);
      bus.Mem_Din = $urandom;
      if (r == 0)      bus.Mem_Addr = BASE + DEPTH * 4 + 32'($urandom_range(0, 63)) * 4;
      else if (r == 1) bus.Mem_Addr = 32'hFFFF_FFFC;
      else             bus.Mem_Addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    end
    bus.cs = 0;
    repeat (6) @(negedge clk);

    // Zero wait states, non-zero base.
    txn0(1, BASE0 + 32'h4, 32'hA5A5_5A5A, q, e, lat);
    chk("w0_st_lat", 32'(lat), 1);
    txn0(0, BASE0 + 32'h4, 32'h0, q, e, lat);
    chk("w0_ld_lat", 32'(lat), 1);
    chk("w0_ld_data", q, 32'hA5A5_5A5A);
    txn0(1, BASE0, 32'h1111_1111, q, e, lat);
    txn0(1, BASE0 + 32'h40, 32'h2222_2222, q, e, lat);
    chk("w0_oor_st_err", 32'(e), 1);
    txn0(0, BASE0, 32'h0, q, e, lat);
    chk("w0_noalias", q, 32'h1111_1111);
    chk("w0_err_clr", 32'(e), 0);
    txn0(0, BASE0 - 32'h4, 32'h0, q, e, lat);
    chk("w0_below_err", 32'(e), 1);
    chk("w0_below_dout", q, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
